// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: widths, op codes, FSM states
// and the latched command payload.
package alu_seq_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 2 * OPND_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_INC   = 3'd0,
        OP_ADDC  = 3'd1,
        OP_ADD   = 3'd2,
        OP_ORXOR = 3'd3,
        OP_RED   = 3'd4,
        OP_CAT   = 3'd5,
        OP_LOAD  = 3'd6,
        OP_CLR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [OPND_W-1:0] data;
    } cmd_t;

    // LOAD and CLEAR never touch the external ALU and always run a single cycle
    function automatic logic is_internal_op(op_e op);
        return (op == OP_LOAD) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a registered zero flag; counts iterations left.
module seq_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;
    logic         zero_q, zero_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared 4-bit ALU: repeats one operation N+1 times,
// feeding the accumulator low nibble back as operand A.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OPND_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_select,
    input  logic [RES_W-1:0]  alu_out,
    output logic [RES_W-1:0]  acc,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_zero;

    seq_down_counter #(.W(CNT_W)) u_iter_cnt (
        .clk        (clock),
        .rst_n      (resetn),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state, accumulator update and registered status outputs
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        acc_d    = acc_q;
        cnt_load = 1'b0;
        cnt_val  = cmd_count;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = EXEC;
                    cmd_d.op   = op_e'(cmd_op);
                    cmd_d.data = cmd_data;
                    cnt_load   = 1'b1;
                    if (is_internal_op(op_e'(cmd_op))) begin
                        cnt_val = '0;
                    end
                end
            end
            EXEC: begin
                // alu_out is only trusted here; it may be undriven elsewhere
                case (cmd_q.op)
                    OP_LOAD: acc_d = RES_W'(cmd_q.data);
                    OP_CLR:  acc_d = '0;
                    default: acc_d = alu_out;
                endcase
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == EXEC);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cmd_q   <= '{op: OP_INC, data: '0};
            acc_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign acc        = acc_q;
    assign alu_a      = acc_q[OPND_W-1:0];
    assign alu_b      = cmd_q.data;
    assign alu_select = cmd_q.op;

endmodule
